gf180mcu_osu_sc_12t_clkbranch_seq: RTL and testbench
====================================================

# gf180mcu_osu_sc_12T_clkbranch_seq

Staggered clock-branch enable sequencer for the 12T clock tree. Drives NBR enable lines to integrated clock gates placed ahead of clkbuf_16 branch drivers, switching branches on (low index first) and off (high index first) one at a time with a programmable cycle gap to limit supply inrush and di/dt. A level REQ/ACK handshake tells the power/clock manager when the tree is fully on or fully off.

## Interface
- NBR, 4: number of clock branches (2..16).
- GAP_W, 4: width of GAP input and internal gap counter.

- CLK  input  1  sequencer clock (ungated root clock); all flops rising-edge.
- RN  input  1  reset, asynchronous, active-low.
- REQ  input  1  level request: 1 = all branches on, 0 = all branches off.
- GAP  input  GAP_W  extra idle cycles between successive branch transitions; sampled on sequence start.
- EN  output  NBR  branch enables, registered, thermometer code (EN[i]=1 implies EN[j]=1 for all j<i).
- ACK  output  1  registered; 1 = tree fully on and stable, 0 = fully off and stable.
- BUSY  output  1  registered; 1 while a ramp is in progress.

## Operation
- Reset is asynchronous and active-low. While RN=0: EN=0, ACK=0, BUSY=0, state IDLE_OFF, gap counter CNT=0, latched gap G=0. Reset mid-ramp drops all branches at once (accepted).
- States: IDLE_OFF, RAMP_UP, IDLE_ON, RAMP_DOWN.
- IDLE_OFF, REQ=1 at edge: G<=GAP, CNT<=GAP, EN[0]<=1, BUSY<=1, go RAMP_UP.
- IDLE_ON, REQ=0 at edge: G<=GAP, CNT<=GAP, clear EN[NBR-1], BUSY<=1, go RAMP_DOWN.
- Idle states with REQ matching ACK: hold; GAP ignored.
- In a ramp, each edge with CNT!=0: CNT<=CNT-1, nothing else changes.
- Edge with CNT==0 is a step point; action chosen by current REQ:
  - REQ=1, EN not all ones: set lowest clear bit, CNT<=G, state RAMP_UP.
  - REQ=1, EN all ones: go IDLE_ON, ACK<=1, BUSY<=0.
  - REQ=0, EN not zero: clear highest set bit, CNT<=G, state RAMP_DOWN.
  - REQ=0, EN zero: go IDLE_OFF, ACK<=0, BUSY<=0.
- Reversal: a REQ change during a ramp takes effect only at the next step point; EN continues from its current pattern in the new direction. G is not resampled on reversal.
- At most one EN bit changes per edge; EN never leaves thermometer code.
- ACK changes only on entry to IDLE_ON (to 1) or IDLE_OFF (to 0); during ramps it holds its previous value.
- REQ pulses shorter than one step interval may be missed only if REQ returns to the current ACK value before the next step point; this is intended.

## Timing
- Let e0 = edge sampling the REQ change in an idle state, and P = GAP+1.
- Up: EN[i] rises at e0 + i*P. ACK rises and BUSY falls at e0 + NBR*P.
- Down: EN[NBR-1-i] falls at e0 + i*P. ACK falls and BUSY falls at e0 + NBR*P.
- BUSY rises at e0.
- Example, GAP=0 and NBR=4: EN goes 0001, 0011, 0111, 1111 at e0..e0+3, and ACK=1 at e0+4.
- No combinational path from any input to any output.
- Counter arithmetic is unsigned, GAP_W bits, with no wrap: decrement happens only when CNT!=0.
- Maximum GAP (2^GAP_W-1) gives P=2^GAP_W.

## Test plan
- Reset: assert RN low mid-RAMP_UP with EN=0011 -> EN=0, ACK=0, BUSY=0 immediately, without waiting for an edge; after release with REQ=0 everything stays idle.
- Power-up, GAP=0, NBR=4: REQ 0->1 -> EN 0001/0011/0111/1111 on consecutive edges, ACK=1 and BUSY=0 on the 5th edge.
- Power-down, GAP=2: from IDLE_ON drop REQ -> EN 0111 at e0, 0011 at e0+3, 0001 at e0+6, 0000 at e0+9; ACK=0 at e0+12.
- Reversal, GAP=3: raise REQ, then drop it at e0+2 (EN=0001, CNT=1) -> EN holds until step point e0+4, then EN=0000 there; ACK stays 0; IDLE_OFF, BUSY=0 at e0+8.
- GAP sampling: start a ramp with GAP=1, change GAP to 7 mid-ramp -> spacing stays 2 cycles for the whole ramp, including after a reversal.
- Boundary and checker: GAP=15 gives 16-cycle spacing. A continuous assertion checks that EN is thermometer code, that at most one EN bit toggles per edge, and that ACK toggles only when BUSY falls.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_clkbranch_seq.sv
// Staggered clock-branch enable sequencer: ramps branch ICG enables on low-first
// and off high-first, one bit per step, with a programmable idle gap between steps.
module gf180mcu_osu_sc_12t_clkbranch_seq #(
    parameter int NBR   = 4,
    parameter int GAP_W = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ,
    input  logic [GAP_W-1:0] GAP,
    output logic [NBR-1:0]   EN,
    output logic             ACK,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE_OFF  = 2'd0,
        RAMP_UP   = 2'd1,
        IDLE_ON   = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [NBR-1:0]   r_en, w_en_nxt;
    logic [GAP_W-1:0] r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0] r_g, w_g_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_busy, w_busy_nxt;

    logic [NBR-1:0]   w_en_up;
    logic [NBR-1:0]   w_en_dn;
    logic             w_en_all;
    logic             w_en_none;
    logic             w_cnt_zero;

    // EN is always thermometer code, so a shift adds the lowest clear bit
    // or removes the highest set bit.
    assign w_en_up    = {r_en[NBR-2:0], 1'b1};
    assign w_en_dn    = {1'b0, r_en[NBR-1:1]};
    assign w_en_all   = &r_en;
    assign w_en_none  = ~|r_en;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= IDLE_OFF;
            r_en    <= '0;
            r_cnt   <= '0;
            r_g     <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
            r_cnt   <= w_cnt_nxt;
            r_g     <= w_g_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = r_en;
        w_cnt_nxt   = r_cnt;
        w_g_nxt     = r_g;
        w_ack_nxt   = r_ack;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE_OFF: begin
                if (REQ) begin
                    w_g_nxt     = GAP;
                    w_cnt_nxt   = GAP;
                    w_en_nxt    = w_en_up;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = RAMP_UP;
                end
            end
            IDLE_ON: begin
                if (!REQ) begin
                    w_g_nxt     = GAP;
                    w_cnt_nxt   = GAP;
                    w_en_nxt    = w_en_dn;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = RAMP_DOWN;
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                // Direction at each step point follows the live REQ, so a
                // reversal simply continues from the current EN pattern.
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - GAP_W'(1);
                end else if (REQ) begin
                    if (w_en_all) begin
                        w_state_nxt = IDLE_ON;
                        w_ack_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_en_nxt    = w_en_up;
                        w_cnt_nxt   = r_g;
                        w_state_nxt = RAMP_UP;
                    end
                end else begin
                    if (w_en_none) begin
                        w_state_nxt = IDLE_OFF;
                        w_ack_nxt   = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_en_nxt    = w_en_dn;
                        w_cnt_nxt   = r_g;
                        w_state_nxt = RAMP_DOWN;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE_OFF;
            end
        endcase
    end

    assign EN   = r_en;
    assign ACK  = r_ack;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkbranch_seq.sv
// Directed bench for the clock-branch sequencer: table-driven up/down ramps plus
// hand sequences for reversal, GAP sampling, max GAP and async reset.
module tb_gf180mcu_osu_sc_12t_clkbranch_seq;

    logic       clk;
    logic       rn;
    logic       req;
    logic [3:0] gap;
    logic [3:0] en;
    logic       ack;
    logic       busy;

    int total = 0;
    int bad   = 0;

    gf180mcu_osu_sc_12t_clkbranch_seq #(.NBR(4), .GAP_W(4)) dut (
        .CLK  (clk),
        .RN   (rn),
        .REQ  (req),
        .GAP  (gap),
        .EN   (en),
        .ACK  (ack),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [3:0] gap;
        logic [3:0] en;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t vt[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] en_e, input logic ack_e,
                       input logic busy_e);
        total++;
        if (en !== en_e || ack !== ack_e || busy !== busy_e) begin
            bad++;
            $display("FAIL %s: got EN=%b ACK=%b BUSY=%b, want EN=%b ACK=%b BUSY=%b",
                     nm, en, ack, busy, en_e, ack_e, busy_e);
        end
    endtask

    // Continuous structural checks sampled mid-cycle.
    logic [3:0] p_en;
    logic       p_ack, p_busy, p_vld;
    initial p_vld = 1'b0;
    always @(negedge clk) begin
        if (!rn) begin
            p_vld = 1'b0;
        end else begin
            total++;
            if ((en & (en + 4'd1)) != 4'd0) begin
                bad++;
                $display("FAIL thermo: EN=%b not thermometer code", en);
            end
            if (p_vld) begin
                total++;
                if ($countones(en ^ p_en) > 1) begin
                    bad++;
                    $display("FAIL one_bit: EN %b -> %b", p_en, en);
                end
                total++;
                if (ack != p_ack && !(p_busy && !busy)) begin
                    bad++;
                    $display("FAIL ack_rule: ACK %b->%b with BUSY %b->%b", p_ack, ack, p_busy, busy);
                end
            end
            p_en   = en;
            p_ack  = ack;
            p_busy = busy;
            p_vld  = 1'b1;
        end
    end

    initial begin
        logic [3:0] gs_en[13];
        logic       gs_busy[13];
        logic       gs_ack[13];
        int n;

        // Power-up GAP=0; GAP on non-start rows is junk and must be ignored.
        n = 0;
        vt[n++] = '{1'b1, 4'd0, 4'b0001, 1'b0, 1'b1};
        vt[n++] = '{1'b1, 4'd5, 4'b0011, 1'b0, 1'b1};
        vt[n++] = '{1'b1, 4'd5, 4'b0111, 1'b0, 1'b1};
        vt[n++] = '{1'b1, 4'd5, 4'b1111, 1'b0, 1'b1};
        vt[n++] = '{1'b1, 4'd5, 4'b1111, 1'b1, 1'b0};
        vt[n++] = '{1'b1, 4'd9, 4'b1111, 1'b1, 1'b0};
        // Power-down GAP=2: steps every 3 edges, ACK holds 1 until the end.
        vt[n++] = '{1'b0, 4'd2, 4'b0111, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0111, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0111, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0011, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0011, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0011, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0001, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0001, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0001, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0000, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0000, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0000, 1'b1, 1'b1};
        vt[n++] = '{1'b0, 4'd9, 4'b0000, 1'b0, 1'b0};

        rn  = 1'b0;
        req = 1'b0;
        gap = 4'd0;
        #12;
        chk("reset_state", 4'b0000, 1'b0, 1'b0);
        rn = 1'b1;
        tick();
        chk("idle_after_reset", 4'b0000, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            req = vt[i].req;
            gap = vt[i].gap;
            tick();
            chk($sformatf("table_%0d", i), vt[i].en, vt[i].ack, vt[i].busy);
        end

        // Reversal, GAP=3: drop REQ after e0+2; the change lands at step e0+4.
        req = 1'b1;
        gap = 4'd3;
        tick();
        chk("rev_e0", 4'b0001, 1'b0, 1'b1);
        tick();
        tick();
        chk("rev_e2", 4'b0001, 1'b0, 1'b1);
        req = 1'b0;
        tick();
        chk("rev_e3", 4'b0001, 1'b0, 1'b1);
        tick();
        chk("rev_e4", 4'b0000, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        chk("rev_e7", 4'b0000, 1'b0, 1'b1);
        tick();
        chk("rev_e8", 4'b0000, 1'b0, 1'b0);

        // GAP sampled at start only: GAP=1 ramp, GAP moved to 7, reversal at e0+4.
        gs_en   = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0011,
                    4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        gs_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        gs_ack  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        req = 1'b1;
        gap = 4'd1;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("gapsamp_e%0d", i), gs_en[i], gs_ack[i], gs_busy[i]);
            if (i == 0) gap = 4'd7;
            if (i == 4) req = 1'b0;
        end

        // Max GAP=15 gives 16-cycle spacing; then async reset at EN=0011.
        req = 1'b1;
        gap = 4'd15;
        tick();
        chk("gap15_e0", 4'b0001, 1'b0, 1'b1);
        repeat (15) tick();
        chk("gap15_e15", 4'b0001, 1'b0, 1'b1);
        tick();
        chk("gap15_e16", 4'b0011, 1'b0, 1'b1);
        #2;
        rn = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 1'b0, 1'b0);
        req = 1'b0;
        #3;
        rn = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle", 4'b0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
